// File: rtl/eth_tx_framer_if.sv
//------------------------------------------------------------------------------
// eth_tx_framer_if
//   Dibit stream between the pixel/address serializer and the Ethernet TX
//   framer.
//
//   axiiv  : dibit valid, driven by the serializer
//   axiid  : dibit value; axiid[0] is the earlier bit on the wire
//   stall  : backpressure from the framer while a frame is being finished
//
//   master : serializer side
//   slave  : framer side
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface eth_tx_framer_if;
   logic       axiiv;
   logic [1:0] axiid;
   logic       stall;

   modport master (output axiiv, output axiid, input  stall);
   modport slave  (input  axiiv, input  axiid, output stall);
endinterface

// File: rtl/eth_tx_framer.sv
//------------------------------------------------------------------------------
// eth_tx_framer
//   Wraps each contiguous valid dibit burst from the serializer in an Ethernet
//   frame and drives the RMII transmit pins:
//     preamble + SFD (32 dibits), payload delayed by 32 cycles, zero pad up to
//     MIN_PAYLOAD_BYTES, CRC-32 FCS (16 dibits), then IFG_CYCLES of idle.
//
// Ports
//   clk        : RMII 50 MHz reference clock
//   rst        : asynchronous, active-low reset
//   up         : serializer stream (axiiv/axiid in, stall out)
//   txen       : RMII TX_EN
//   txd        : RMII TXD, txd[0] is the earlier bit
//   frame_done : one-cycle pulse on the last FCS dibit
//   frame_err  : one-cycle pulse when capture is cut at MAX_PAYLOAD_BYTES
//
// All outputs are registered. MIN_PAYLOAD_BYTES must not exceed
// MAX_PAYLOAD_BYTES, since the output byte counter saturates at the maximum.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module eth_tx_framer #(
   parameter int MIN_PAYLOAD_BYTES = 60,
   parameter int MAX_PAYLOAD_BYTES = 1500,
   parameter int IFG_CYCLES        = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   eth_tx_framer_if.slave       up,
   output logic                 txen,
   output logic [1:0]           txd,
   output logic                 frame_done,
   output logic                 frame_err
);

   localparam int          DL_DEPTH  = 32;
   localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
   localparam int          PHASE_MAX = (IFG_CYCLES > 32) ? IFG_CYCLES : 32;
   localparam int          CNT_W     = $clog2(PHASE_MAX + 1);

   localparam logic [10:0]      MAX_BYTES    = 11'(MAX_PAYLOAD_BYTES);
   localparam logic [10:0]      MAX_BYTES_M1 = 11'(MAX_PAYLOAD_BYTES - 1);
   localparam logic [CNT_W-1:0] PRE_LAST     = CNT_W'(31);
   localparam logic [CNT_W-1:0] PRE_DONE     = CNT_W'(32);
   localparam logic [CNT_W-1:0] FCS_LAST     = CNT_W'(15);
   localparam logic [CNT_W-1:0] FCS_DONE     = CNT_W'(16);
   localparam logic [CNT_W-1:0] IFG_DONE     = CNT_W'(IFG_CYCLES);

   typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} state_t;
   typedef enum logic [1:0] {EMIT_DATA, EMIT_PAD, EMIT_FCS} emit_t;

   state_t             state;
   logic [CNT_W-1:0]   phase_cnt;   // dibits/cycles spent in PREAMBLE, FCS, IFG
   logic               capturing;
   logic [1:0]         dl_data [DL_DEPTH];
   logic [DL_DEPTH-1:0] dl_vld;
   logic [1:0]         cap_dibit;
   logic [10:0]        cap_bytes;
   logic [1:0]         out_dibit;
   logic [10:0]        out_bytes;
   logic [31:0]        crc;
   logic               stall_q;

   logic               take;
   logic               cap_last;
   logic               pad_needed;
   logic               pay_step;
   emit_t              emit_sel;
   logic [1:0]         pay_dibit;

   assign up.stall = stall_q;

   // Reflected CRC-32 advanced by one dibit, bit 0 first.
   function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      // NOTE: blocking assignments inside a function are evaluated in order,
      // which is exactly the bit-serial recurrence wanted here.
      for (int i = 0; i < 2; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      take       = 1'b0;
      cap_last   = 1'b0;
      pad_needed = 1'b0;
      pay_step   = 1'b0;
      emit_sel   = EMIT_FCS;
      pay_dibit  = 2'b00;

      // A frame always starts on a valid cycle in IDLE; afterwards only an
      // unbroken run of valid cycles is accepted.
      if (state == IDLE) take = up.axiiv;
      else               take = capturing && up.axiiv;

      cap_last = take && (cap_dibit == 2'd3) && (cap_bytes == MAX_BYTES_M1);

      pad_needed = (out_dibit != 2'd0) || (int'(out_bytes) < MIN_PAYLOAD_BYTES);

      // The delay line is filled contiguously from the first dibit, so an
      // invalid tail can only be seen once capture has ended.
      if (dl_vld[DL_DEPTH-1]) begin
         emit_sel  = EMIT_DATA;
         pay_dibit = dl_data[DL_DEPTH-1];
      end else if (pad_needed) begin
         emit_sel  = EMIT_PAD;
      end

      pay_step = ((state == PREAMBLE) && (phase_cnt == PRE_DONE)) ||
                 (state == DATA) || (state == PAD);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         phase_cnt  <= '0;
         capturing  <= 1'b0;
         dl_vld     <= '0;
         // NOTE: the delay line is a shift register, not a RAM, so clearing
         // it on reset costs nothing and keeps txd deterministic.
         for (int i = 0; i < DL_DEPTH; i++) dl_data[i] <= 2'b00;
         cap_dibit  <= '0;
         cap_bytes  <= '0;
         out_dibit  <= '0;
         out_bytes  <= '0;
         crc        <= CRC_INIT;
         stall_q    <= 1'b0;
         txen       <= 1'b0;
         txd        <= 2'b00;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         // ---------------- capture side ----------------
         dl_vld     <= {dl_vld[DL_DEPTH-2:0], take};
         dl_data[0] <= take ? up.axiid : 2'b00;
         for (int i = 1; i < DL_DEPTH; i++) dl_data[i] <= dl_data[i-1];

         if (take) begin
            cap_dibit <= cap_dibit + 2'd1;
            if ((cap_dibit == 2'd3) && (cap_bytes != MAX_BYTES))
               cap_bytes <= cap_bytes + 11'd1;
         end

         if (state == IDLE) begin
            capturing <= up.axiiv;
         end else if (capturing && (!up.axiiv || cap_last)) begin
            capturing <= 1'b0;
            stall_q   <= 1'b1;
            frame_err <= cap_last;
         end

         // ---------------- output side ----------------
         if (pay_step) begin
            if (emit_sel == EMIT_FCS) begin
               state     <= FCS;
               txd       <= ~crc[1:0];
               crc       <= crc >> 2;
               phase_cnt <= CNT_W'(1);
            end else begin
               state     <= (emit_sel == EMIT_DATA) ? DATA : PAD;
               txd       <= pay_dibit;
               crc       <= crc_dibit(crc, pay_dibit);
               out_dibit <= out_dibit + 2'd1;
               if ((out_dibit == 2'd3) && (out_bytes != MAX_BYTES))
                  out_bytes <= out_bytes + 11'd1;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (up.axiiv) begin
                     state     <= PREAMBLE;
                     txen      <= 1'b1;
                     txd       <= 2'b01;
                     phase_cnt <= CNT_W'(1);
                  end
               end
               PREAMBLE: begin
                  // 31 x 01 then the closing 11 of the SFD.
                  txd       <= (phase_cnt == PRE_LAST) ? 2'b11 : 2'b01;
                  phase_cnt <= phase_cnt + 1'b1;
               end
               FCS: begin
                  if (phase_cnt == FCS_DONE) begin
                     state     <= IFG;
                     txen      <= 1'b0;
                     txd       <= 2'b00;
                     phase_cnt <= CNT_W'(1);
                  end else begin
                     // crc is shifted as it is sent, so bits [1:0] are always next.
                     txd        <= ~crc[1:0];
                     crc        <= crc >> 2;
                     phase_cnt  <= phase_cnt + 1'b1;
                     frame_done <= (phase_cnt == FCS_LAST);
                  end
               end
               IFG: begin
                  if (phase_cnt == IFG_DONE) begin
                     state     <= IDLE;
                     stall_q   <= 1'b0;
                     crc       <= CRC_INIT;
                     phase_cnt <= '0;
                     cap_dibit <= '0;
                     cap_bytes <= '0;
                     out_dibit <= '0;
                     out_bytes <= '0;
                  end else begin
                     phase_cnt <= phase_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Stage directly downstream of the pixel/address dibit serializer; consumes its axiiv/axiid 2-bit stream and drives the RMII transmit pins.
- Wraps each contiguous valid burst in an Ethernet frame: preamble+SFD, delayed payload, zero pad, CRC-32 FCS, inter-frame gap.
- Asserts stall back to the serializer while finishing a frame, so the next burst starts only after the gap.

Parameters:
MIN_PAYLOAD_BYTES, 60, payload (header+data) padded with zero bytes up to this length before FCS
MAX_PAYLOAD_BYTES, 1500, capture force-terminated after this many bytes
IFG_CYCLES, 48, txen-low dibit cycles after FCS (12 byte-times)

Ports:
clk  in  1  RMII 50 MHz reference clock
rst  in  1  asynchronous, active-low reset
axiiv  in  1  upstream dibit valid
axiid  in  2  upstream dibit; axiid[0] is the earlier bit on the wire
stall  out  1  backpressure to the serializer
txen  out  1  RMII TX_EN
txd  out  2  RMII TXD; txd[0] is the earlier bit
frame_done  out  1  one-cycle pulse on the last FCS dibit
frame_err  out  1  one-cycle pulse when capture is truncated at MAX_PAYLOAD_BYTES

Behaviour:
- Reset (rst low, async): FSM=IDLE; txen, txd, stall, frame_done and frame_err all 0; delay line cleared; CRC=32'hFFFFFFFF; all counters 0.
- All outputs registered.
- Output FSM states: IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
- IDLE: when axiiv=1 in cycle 0:
  - start capture;
  - go to PREAMBLE;
  - txen=1 from cycle 1.
- PREAMBLE (32 cycles, cycles 1..32):
  - txd=2'b01 for 28 cycles;
  - then SFD dibits 01, 01, 01, 11.
- Capture:
  - While capturing, each cycle's axiid is pushed into a 32-entry dibit delay line with per-entry valid bit.
  - Capture ends on the first cycle with axiiv=0, or when 4*MAX_PAYLOAD_BYTES dibits have been taken. The latter pulses frame_err.
  - After capture ends, axiiv is ignored until IDLE. Re-asserting axiiv mid-frame has no effect.
- Latency: payload dibit k appears on txd at cycle 33+k.
- DATA: output the delay-line tail while its valid bit is set. When the tail is invalid and capture has ended, go to PAD.
- PAD:
  - Emit 2'b00 dibits until the dibit count is a multiple of 4 (byte boundary).
  - Continue until the byte count is at least MIN_PAYLOAD_BYTES.
  - Zero pad dibits are CRC'd.
  - PAD may take 0 cycles.
- CRC:
  - Reflected polynomial 32'hEDB88320, init all ones.
  - Updated on every DATA/PAD dibit, txd[0] first, then txd[1].
  - FCS = ~crc, sent as 16 dibits starting from bits [1:0] up to [31:30].
- FCS (16 cycles): frame_done pulses with the final dibit.
- IFG:
  - txen=0, txd=0 for IFG_CYCLES cycles;
  - then IDLE, with CRC and counters reinitialised.
- stall:
  - Goes to 1 the cycle after capture ends.
  - Held through PAD, FCS and IFG.
  - Returns to 0 on entry to IDLE.
  - stall is 0 during PREAMBLE and capture.
- Short payloads (fewer than 32 dibits): capture ends during PREAMBLE, and DATA still drains correctly.
- Zero-length burst cannot occur, since a capture always starts with the valid cycle.
- Counters:
  - Byte counter is 11 bits and saturates at MAX_PAYLOAD_BYTES.
  - Dibit counter is 2 bits and wraps.
- Reset mid-frame: immediate return to the reset state, with txen low in the same edge (async).

Test Plan:
1. MIN_PAYLOAD_BYTES=0; send ASCII "123456789" (36 dibits, LSB dibit first), then axiiv low.
   - Expected txd: 28×01, then 01,01,01,11, then the 36 payload dibits.
   - FCS 0xCBF43926 as dibits 2,1,2,0, 1,2,3,0, 0,1,3,3, 3,2,0,3 (0x26, 0x39, 0xF4, 0xCB order).
   - frame_done on the last FCS dibit, then 48 cycles txen=0.
2. Default params; 4-byte burst 0xDE 0xAD 0xBE 0xEF.
   - 56 zero pad bytes follow; total payload 60 bytes.
   - txen high for exactly 32+240+16=288 cycles.
   - FCS matches the software CRC-32 of the padded 60 bytes.
3. 7-dibit burst (non-byte-aligned): 1 zero dibit is inserted before byte padding; the payload dibit total is 240.
4. axiiv held high with MAX_PAYLOAD_BYTES=64:
   - capture stops after 256 dibits;
   - frame_err pulses once;
   - stall rises the next cycle;
   - the frame is completed normally.
5. axiiv toggled high during FCS and IFG:
   - no effect on the current frame; stall stays 1;
   - a new frame starts only on axiiv=1 after stall falls.
6. rst driven low at payload dibit 10:
   - txen, txd and stall are 0 immediately;
   - after release, a fresh burst produces a correct preamble and FCS (CRC reinitialised).
